// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the operand sequencer: FSM state encoding and the
// width/size helper functions used to derive beat count and index widths.
// Contents: state_t (IDLE=0, RUN=1), ceil_div(), clog2(), iw_of().
package operand_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Integer ceiling division, used for the number of beats per vector.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width: at least one bit even when N = 1.
  function automatic int iw_of(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/operand_sequencer_if.sv
// Bundle for the operand sequencer: start/vector load side plus the
// valid/ready beat stream and status (busy, done).
// Ports: master = vector source and beat sink; slave = the sequencer itself.
interface operand_sequencer_if
  import operand_sequencer_pkg::*;
#(
  parameter int N     = 10,
  parameter int DW    = 8,
  parameter int LANES = 2
) ();

  localparam int IW = iw_of(N);

  logic                  start;
  logic [N*DW-1:0]       in_vec;
  logic [N*DW-1:0]       weight_vec;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*DW-1:0]   out_inp;
  logic [LANES*DW-1:0]   out_weight;
  logic [LANES-1:0]      out_mask;
  logic [IW-1:0]         out_idx;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport master (
    output start, in_vec, weight_vec, out_ready,
    input  out_valid, out_inp, out_weight, out_mask, out_idx, out_last, busy, done
  );

  modport slave (
    input  start, in_vec, weight_vec, out_ready,
    output out_valid, out_inp, out_weight, out_mask, out_idx, out_last, busy, done
  );

endinterface

// File: rtl/operand_sequencer_lane_mux.sv
// Purpose: selects one input/weight element pair by index; zero-fills when
//   the index is past the end of the vector or the lane is disabled.
// Latency: combinational. Backpressure: none (pure mux).
// Ports: i_en, i_idx, i_inp_vec, i_wgt_vec -> o_inp, o_wgt, o_mask.
module lane_mux #(
  parameter int N  = 10,
  parameter int DW = 8,
  parameter int XW = 5
) (
  input  logic            i_en,
  input  logic [XW-1:0]   i_idx,
  input  logic [N*DW-1:0] i_inp_vec,
  input  logic [N*DW-1:0] i_wgt_vec,
  output logic [DW-1:0]   o_inp,
  output logic [DW-1:0]   o_wgt,
  output logic            o_mask
);

  // Compare-and-select over the N elements: an index >= N matches nothing,
  // so the zero defaults fall through without an out-of-range part-select.
  always_comb begin
    o_inp  = '0;
    o_wgt  = '0;
    o_mask = 1'b0;
    if (i_en) begin
      for (int k = 0; k < N; k++) begin
        if (int'(i_idx) == k) begin
          o_inp  = i_inp_vec[k*DW +: DW];
          o_wgt  = i_wgt_vec[k*DW +: DW];
          o_mask = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// Purpose: captures an input vector and a weight vector on start, then
//   streams them out LANES element pairs per beat over valid/ready.
// Latency: first beat valid the cycle after start; done pulses the cycle
//   after the final beat transfers. Backpressure: out_ready low stalls the
//   beat counter and holds all outputs; out_valid never depends on out_ready.
// Ports: clk, rst (sync, active-high), bus (operand_sequencer_if.slave).
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int N     = 10,
  parameter int DW    = 8,
  parameter int LANES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_sequencer_if.slave   bus
);

  localparam int BEATS = ceil_div(N, LANES);
  localparam int IW    = iw_of(N);
  // Lane indices run up to BEATS*LANES-1, which can exceed N-1.
  localparam int XW    = clog2(N + LANES) + 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_beat;
  logic [IW-1:0]     w_beat_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic [N*DW-1:0]   r_inp;
  logic [N*DW-1:0]   r_wgt;

  logic              w_run;
  logic              w_load;
  logic              w_last;
  logic              w_xfer;
  logic [XW-1:0]     w_base;

  logic [LANES-1:0][DW-1:0] w_lane_inp;
  logic [LANES-1:0][DW-1:0] w_lane_wgt;
  logic [LANES-1:0]         w_lane_mask;

  // State, beat counter, done pulse and captured vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_done  <= 1'b0;
      r_inp   <= '0;
      r_wgt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_inp <= bus.in_vec;
        r_wgt <= bus.weight_vec;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_done_nxt  = 1'b0;
    w_run       = (r_state == ST_RUN);
    w_last      = w_run && (r_beat == IW'(BEATS - 1));
    w_xfer      = w_run && bus.out_ready;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_beat_nxt  = '0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_xfer) begin
          if (w_last) begin
            w_beat_nxt  = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_beat_nxt  = r_beat + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Element index of lane 0 for the current beat.
  assign w_base = XW'(r_beat) * XW'(LANES);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_mux #(
      .N  (N),
      .DW (DW),
      .XW (XW)
    ) u_lane_mux (
      .i_en      (w_run),
      .i_idx     (w_base + XW'(l)),
      .i_inp_vec (r_inp),
      .i_wgt_vec (r_wgt),
      .o_inp     (w_lane_inp[l]),
      .o_wgt     (w_lane_wgt[l]),
      .o_mask    (w_lane_mask[l])
    );
  end

  // Outputs are decoded from registered state only, so they are zero in
  // IDLE and cannot glitch with out_ready.
  assign bus.out_valid  = w_run;
  assign bus.busy       = w_run;
  assign bus.done       = r_done;
  assign bus.out_last   = w_last;
  assign bus.out_idx    = w_run ? IW'(w_base) : '0;
  assign bus.out_inp    = w_lane_inp;
  assign bus.out_weight = w_lane_wgt;
  assign bus.out_mask   = w_lane_mask;

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;

  typedef logic [7:0] vec_t [10];

  typedef struct packed {
    logic [3:0]  idx;
    logic [79:0] inp;
    logic [79:0] wgt;
    logic [9:0]  mask;
    logic        last;
  } beat_t;

  logic clk;
  logic rst;

  operand_sequencer_if #(.N(10), .DW(8), .LANES(4))  if_a ();
  operand_sequencer_if #(.N(10), .DW(8), .LANES(10)) if_b ();

  operand_sequencer #(.N(10), .DW(8), .LANES(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  operand_sequencer #(.N(10), .DW(8), .LANES(10)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  beat_t q_a [$];
  beat_t q_b [$];

  vec_t v_in, v_w, v_alt;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference beat: lane l carries element b*lanes+l, zero past element 9.
  function automatic beat_t model(input int lanes, input int b, input vec_t vi, input vec_t vw);
    beat_t r;
    int e;
    r = '0;
    r.idx = 4'(b * lanes);
    for (int l = 0; l < lanes; l++) begin
      e = b * lanes + l;
      if (e < 10) begin
        r.inp[l*8 +: 8] = vi[e];
        r.wgt[l*8 +: 8] = vw[e];
        r.mask[l]       = 1'b1;
      end
    end
    r.last = (b == ((10 + lanes - 1) / lanes) - 1);
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_vecs(input vec_t vi, input vec_t vw);
    for (int i = 0; i < 10; i++) begin
      if_a.in_vec[i*8 +: 8]     = vi[i];
      if_a.weight_vec[i*8 +: 8] = vw[i];
      if_b.in_vec[i*8 +: 8]     = vi[i];
      if_b.weight_vec[i*8 +: 8] = vw[i];
    end
  endtask

  task automatic push_a(input vec_t vi, input vec_t vw);
    for (int b = 0; b < 3; b++) q_a.push_back(model(4, b, vi, vw));
  endtask

  task automatic wait_done_a(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      cyc(1);
      if (if_a.done === 1'b1) seen = 1'b1;
    end
    check("a_done_wait", 128'(seen), 128'd1);
  endtask

  // Scoreboard monitor: a beat transfers at the next rising edge when
  // valid and ready are both high here. Also checks stall stability.
  beat_t e_a, e_b;
  bit    a_stall = 1'b0;
  logic [3:0]  h_idx;
  logic [31:0] h_inp, h_wgt;
  logic [3:0]  h_mask;
  logic        h_last;

  always @(negedge clk) begin
    if (rst) begin
      a_stall = 1'b0;
    end else begin
      if (a_stall) begin
        check("a_hold_valid", 128'(if_a.out_valid), 128'd1);
        check("a_hold_idx",   128'(if_a.out_idx),   128'(h_idx));
        check("a_hold_inp",   128'(if_a.out_inp),   128'(h_inp));
        check("a_hold_wgt",   128'(if_a.out_weight),128'(h_wgt));
        check("a_hold_mask",  128'(if_a.out_mask),  128'(h_mask));
        check("a_hold_last",  128'(if_a.out_last),  128'(h_last));
      end
      if (if_a.out_valid && if_a.out_ready) begin
        if (q_a.size() == 0) begin
          check("a_extra_beat", 128'd1, 128'd0);
        end else begin
          e_a = q_a.pop_front();
          check("a_idx",  128'(if_a.out_idx),    128'(e_a.idx));
          check("a_inp",  128'(if_a.out_inp),    128'(e_a.inp[31:0]));
          check("a_wgt",  128'(if_a.out_weight), 128'(e_a.wgt[31:0]));
          check("a_mask", 128'(if_a.out_mask),   128'(e_a.mask[3:0]));
          check("a_last", 128'(if_a.out_last),   128'(e_a.last));
        end
      end
      a_stall = if_a.out_valid && !if_a.out_ready;
      h_idx   = if_a.out_idx;
      h_inp   = if_a.out_inp;
      h_wgt   = if_a.out_weight;
      h_mask  = if_a.out_mask;
      h_last  = if_a.out_last;
      if (if_b.out_valid && if_b.out_ready) begin
        if (q_b.size() == 0) begin
          check("b_extra_beat", 128'd1, 128'd0);
        end else begin
          e_b = q_b.pop_front();
          check("b_idx",  128'(if_b.out_idx),    128'(e_b.idx));
          check("b_inp",  128'(if_b.out_inp),    128'(e_b.inp));
          check("b_wgt",  128'(if_b.out_weight), 128'(e_b.wgt));
          check("b_mask", 128'(if_b.out_mask),   128'(e_b.mask));
          check("b_last", 128'(if_b.out_last),   128'(e_b.last));
        end
      end
    end
  end

  initial begin
    rst             = 1'b1;
    if_a.start      = 1'b0;
    if_b.start      = 1'b0;
    if_a.out_ready  = 1'b1;
    if_b.out_ready  = 1'b1;
    if_a.in_vec     = '0;
    if_a.weight_vec = '0;
    if_b.in_vec     = '0;
    if_b.weight_vec = '0;
    for (int i = 0; i < 10; i++) begin
      v_in[i]  = 8'(i + 1);
      v_w[i]   = 8'(8'h10 + i);
      v_alt[i] = 8'(8'hA0 + i);
    end
    cyc(2);

    // Reset state
    check("rst_a_valid", 128'(if_a.out_valid),  128'd0);
    check("rst_a_busy",  128'(if_a.busy),       128'd0);
    check("rst_a_done",  128'(if_a.done),       128'd0);
    check("rst_a_idx",   128'(if_a.out_idx),    128'd0);
    check("rst_a_mask",  128'(if_a.out_mask),   128'd0);
    check("rst_a_last",  128'(if_a.out_last),   128'd0);
    check("rst_a_inp",   128'(if_a.out_inp),    128'd0);
    check("rst_a_wgt",   128'(if_a.out_weight), 128'd0);
    check("rst_b_valid", 128'(if_b.out_valid),  128'd0);
    rst = 1'b0;
    cyc(1);
    check("idle_a_valid", 128'(if_a.out_valid), 128'd0);

    // Basic three-beat run with ready held high
    set_vecs(v_in, v_w);
    if_a.start = 1'b1;
    push_a(v_in, v_w);
    cyc(1);
    if_a.start = 1'b0;
    check("t1_valid", 128'(if_a.out_valid), 128'd1);
    check("t1_busy",  128'(if_a.busy),      128'd1);
    check("t1_idx0",  128'(if_a.out_idx),   128'd0);
    cyc(1);
    check("t1_idx1",  128'(if_a.out_idx),   128'd4);
    check("t1_last1", 128'(if_a.out_last),  128'd0);
    cyc(1);
    check("t1_idx2",  128'(if_a.out_idx),   128'd8);
    check("t1_last2", 128'(if_a.out_last),  128'd1);
    check("t1_mask2", 128'(if_a.out_mask),  128'h3);
    check("t1_inp2",  128'(if_a.out_inp),   128'h00000A09);
    check("t1_done_early", 128'(if_a.done), 128'd0);
    cyc(1);
    check("t1_done",      128'(if_a.done),      128'd1);
    check("t1_valid_end", 128'(if_a.out_valid), 128'd0);
    check("t1_busy_end",  128'(if_a.busy),      128'd0);
    cyc(1);
    check("t1_done_pulse", 128'(if_a.done), 128'd0);

    // Stall for three cycles on beat 1
    if_a.start = 1'b1;
    push_a(v_in, v_w);
    cyc(1);
    if_a.start = 1'b0;
    check("t2_idx0", 128'(if_a.out_idx), 128'd0);
    cyc(1);
    check("t2_idx1", 128'(if_a.out_idx), 128'd4);
    if_a.out_ready = 1'b0;
    repeat (3) begin
      cyc(1);
      check("t2_stall_idx",   128'(if_a.out_idx),   128'd4);
      check("t2_stall_valid", 128'(if_a.out_valid), 128'd1);
    end
    if_a.out_ready = 1'b1;
    wait_done_a(6);
    cyc(1);

    // start during RUN with different vectors is ignored
    set_vecs(v_in, v_w);
    if_a.start = 1'b1;
    push_a(v_in, v_w);
    cyc(1);
    set_vecs(v_alt, v_alt);
    cyc(1);
    if_a.start = 1'b0;
    set_vecs(v_in, v_w);
    wait_done_a(6);
    cyc(1);
    check("t3_no_rerun", 128'(if_a.out_valid), 128'd0);

    // Reset in the middle of a run
    if_a.start = 1'b1;
    push_a(v_in, v_w);
    cyc(1);
    if_a.start = 1'b0;
    cyc(1);
    check("t4_pre_idx", 128'(if_a.out_idx), 128'd4);
    rst = 1'b1;
    cyc(1);
    check("t4_valid", 128'(if_a.out_valid), 128'd0);
    check("t4_busy",  128'(if_a.busy),      128'd0);
    check("t4_mask",  128'(if_a.out_mask),  128'd0);
    check("t4_inp",   128'(if_a.out_inp),   128'd0);
    rst = 1'b0;
    q_a.delete();
    repeat (5) begin
      cyc(1);
      check("t4_no_done",  128'(if_a.done),      128'd0);
      check("t4_no_valid", 128'(if_a.out_valid), 128'd0);
    end

    // start accepted in the done cycle
    if_a.start = 1'b1;
    push_a(v_in, v_w);
    cyc(1);
    if_a.start = 1'b0;
    cyc(3);
    check("t5_done", 128'(if_a.done), 128'd1);
    if_a.start = 1'b1;
    push_a(v_in, v_w);
    cyc(1);
    if_a.start = 1'b0;
    check("t5_restart_valid", 128'(if_a.out_valid), 128'd1);
    check("t5_restart_idx",   128'(if_a.out_idx),   128'd0);
    check("t5_restart_done",  128'(if_a.done),      128'd0);
    wait_done_a(6);
    cyc(1);

    // LANES = N: single beat
    if_b.start = 1'b1;
    q_b.push_back(model(10, 0, v_in, v_w));
    cyc(1);
    if_b.start = 1'b0;
    check("t6_valid", 128'(if_b.out_valid), 128'd1);
    check("t6_last",  128'(if_b.out_last),  128'd1);
    check("t6_mask",  128'(if_b.out_mask),  128'h3FF);
    check("t6_done0", 128'(if_b.done),      128'd0);
    cyc(1);
    check("t6_done",     128'(if_b.done),      128'd1);
    check("t6_valid_end",128'(if_b.out_valid), 128'd0);
    cyc(2);

    check("q_a_empty", 128'(q_a.size()), 128'd0);
    check("q_b_empty", 128'(q_b.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
